// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: default widths,
// FSM state encoding and the packed bundle of latch-control outputs.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEF       = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_flush;
    logic pc_redirect;
  } ctrl_t;

  // One constant per decode outcome; a memory stall and HALT share a pattern
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_NONE   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and the load in EX.
// Purely combinational so the forwarding unit can reuse it.
module pipe_hazard_ctrl_hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_regwrite,
  output logic             loaduse
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit  = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit  = id_uses_rt & (id_rt == ex_rd);
  // Register 0 is hardwired, so a load targeting it never creates a hazard
  assign loaduse = ex_is_load & ex_regwrite & (ex_rd != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: decodes stall/flush/enable controls for the five stage
// latches and tracks memory-wait timeout and performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_regwrite,
  input  logic             mem_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           dbg_state
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              memstall;
  logic              loaduse;
  ctrl_t             ctrl;

  assign memstall  = mem_req & ~mem_ready;
  assign dbg_state = state;

  pipe_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_regwrite (ex_regwrite),
    .loaduse     (loaduse)
  );

  // Priority: reset, halt, memory stall, taken branch, load-use bubble
  always_comb begin
    ctrl = CTRL_NONE;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (state == ST_HALT) begin
      ctrl = CTRL_FREEZE;
    end else if (memstall) begin
      ctrl = CTRL_FREEZE;
    end else if (mem_br_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (loaduse) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign pc_redirect = ctrl.pc_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ctrl.pc_redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (memstall) begin
            state    <= ST_MWAIT;
            wait_cnt <= '0;
          end
        end
        ST_MWAIT: begin
          if (!memstall) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT)) begin
            state   <= ST_HALT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          mem_err <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: decode table, hand-written multi-cycle corner
// sequences, then randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int REG_W   = 4;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  // Control vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_flush pc_redirect
  localparam logic [8:0] V_RST   = 9'b001010110;
  localparam logic [8:0] V_FRZ   = 9'b000000010;
  localparam logic [8:0] V_BR    = 9'b111111101;
  localparam logic [8:0] V_LU    = 9'b000111000;
  localparam logic [8:0] V_NONE  = 9'b110101000;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, ex_is_load, ex_regwrite;
  logic             mem_br_taken, mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_flush, pc_redirect, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  state_t           dbg_state;
  logic [8:0]       act_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: halted flag, waiting flag, MWAIT cycles already spent
  bit m_halt, m_wait, m_err;
  int m_wcnt, m_stall, m_flush;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
    .mem_br_taken(mem_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .pc_redirect(pc_redirect),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  assign act_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_flush, pc_redirect};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_vec();
    bit ms, lu;
    ms = mem_req && !mem_ready;
    lu = ex_is_load && ex_regwrite && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (reset)             return V_RST;
    else if (m_halt)       return V_FRZ;
    else if (ms)           return V_FRZ;
    else if (mem_br_taken) return V_BR;
    else if (lu)           return V_LU;
    else                   return V_NONE;
  endfunction

  task automatic model_step();
    logic [8:0] v;
    bit ms;
    v  = model_vec();
    ms = mem_req && !mem_ready;
    if (reset) begin
      m_halt = 0; m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (v[8] == 1'b0) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
      if (v == V_BR)    m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
      if (!m_halt) begin
        if (!ms) begin
          m_wait = 0; m_wcnt = 0;
        end else if (!m_wait) begin
          m_wait = 1; m_wcnt = 0;
        end else if (m_wcnt == TIMEOUT) begin
          m_halt = 1; m_err = 1;
        end else begin
          m_wcnt++;
        end
      end
    end
  endtask

  // Driver tasks: inputs change #1 after the rising edge, checks happen at the falling edge
  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = '0; ex_is_load = 0; ex_regwrite = 0;
    mem_br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    advance();
    advance();
    reset = 0;
  endtask

  typedef struct {
    string            name;
    logic [REG_W-1:0] rs, rt, rd;
    logic             urs, urt, ld, rw, br;
    logic [8:0]       exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    m_halt = 0; m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    clear_inputs();
    reset = 1;

    // Reset held two cycles
    @(negedge clk);
    check("reset_vec_c1", act_vec, V_RST);
    advance();
    @(negedge clk);
    check("reset_vec_c2", act_vec, V_RST);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);
    check("reset_mem_err", mem_err, 0);
    advance();
    reset = 0;
    @(negedge clk);
    check("run_state", dbg_state, ST_RUN);
    check("run_none_vec", act_vec, V_NONE);
    check("run_stall_cnt", stall_cnt, 0);
    check("run_flush_cnt", flush_cnt, 0);
    check("run_mem_err", mem_err, 0);
    advance();

    // Decode table in RUN with no memory traffic
    tbl.push_back('{"lu_rs",        4'd5, 4'd0, 4'd5, 1, 0, 1, 1, 0, V_LU});
    tbl.push_back('{"lu_rt",        4'd1, 4'd9, 4'd9, 0, 1, 1, 1, 0, V_LU});
    tbl.push_back('{"lu_rd0",       4'd0, 4'd0, 4'd0, 1, 1, 1, 1, 0, V_NONE});
    tbl.push_back('{"lu_not_load",  4'd5, 4'd0, 4'd5, 1, 0, 0, 1, 0, V_NONE});
    tbl.push_back('{"lu_no_write",  4'd5, 4'd0, 4'd5, 1, 0, 1, 0, 0, V_NONE});
    tbl.push_back('{"lu_rs_unused", 4'd5, 4'd0, 4'd5, 0, 0, 1, 1, 0, V_NONE});
    tbl.push_back('{"lu_no_match",  4'd3, 4'd4, 4'd5, 1, 1, 1, 1, 0, V_NONE});
    tbl.push_back('{"br_over_lu",   4'd5, 4'd0, 4'd5, 1, 0, 1, 1, 1, V_BR});
    tbl.push_back('{"br_alone",     4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, V_BR});
    tbl.push_back('{"idle",         4'd2, 4'd3, 4'd7, 1, 1, 0, 0, 0, V_NONE});
    foreach (tbl[i]) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_rd = tbl[i].rd;
      id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt;
      ex_is_load = tbl[i].ld; ex_regwrite = tbl[i].rw; mem_br_taken = tbl[i].br;
      @(negedge clk);
      check(tbl[i].name, act_vec, tbl[i].exp);
      advance();
    end

    // Load-use gives exactly one bubble; branch over load-use counts one flush
    do_reset();
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1;
    @(negedge clk);
    check("bubble_cycle", act_vec, V_LU);
    advance();
    ex_is_load = 0; ex_regwrite = 0; ex_rd = 4'd0;
    @(negedge clk);
    check("bubble_done", act_vec, V_NONE);
    check("bubble_stall_cnt", stall_cnt, 1);
    advance();
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 4'd5; mem_br_taken = 1;
    @(negedge clk);
    check("br_lu_vec", act_vec, V_BR);
    advance();
    clear_inputs();
    @(negedge clk);
    check("br_lu_flush_cnt", flush_cnt, 1);
    check("br_lu_stall_cnt", stall_cnt, 1);
    advance();

    // Three-cycle memory wait with a taken branch held throughout
    do_reset();
    mem_req = 1; mem_ready = 0; mem_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mwait_vec", act_vec, V_FRZ);
      advance();
    end
    mem_ready = 1;
    @(negedge clk);
    check("mwait_release_vec", act_vec, V_BR);
    check("mwait_stall_cnt", stall_cnt, 3);
    check("mwait_flush_cnt_before", flush_cnt, 0);
    advance();
    clear_inputs();
    @(negedge clk);
    check("mwait_state_run", dbg_state, ST_RUN);
    check("mwait_flush_cnt", flush_cnt, 1);
    advance();

    // Timeout: six stalled cycles (one in RUN, five in MWAIT), then HALT
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("to_wait_vec", act_vec, V_FRZ);
      check("to_wait_err", mem_err, 0);
      advance();
    end
    @(negedge clk);
    check("to_halt_err", mem_err, 1);
    check("to_halt_state", dbg_state, ST_HALT);
    advance();
    mem_ready = 1; mem_br_taken = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("halt_vec", act_vec, V_FRZ);
      advance();
    end
    @(negedge clk);
    check("halt_err_sticky", mem_err, 1);
    check("stall_cnt_saturated", stall_cnt, SAT);
    advance();
    reset = 1;
    clear_inputs();
    @(negedge clk);
    check("halt_reset_vec", act_vec, V_RST);
    advance();
    reset = 0;
    @(negedge clk);
    check("halt_reset_err", mem_err, 0);
    check("halt_reset_state", dbg_state, ST_RUN);
    check("halt_reset_stall_cnt", stall_cnt, 0);
    check("halt_reset_vec_none", act_vec, V_NONE);
    advance();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) < 2);
      id_rs        = REG_W'($urandom_range(0, 3));
      id_rt        = REG_W'($urandom_range(0, 3));
      ex_rd        = REG_W'($urandom_range(0, 3));
      id_uses_rs   = $urandom_range(0, 1) == 1;
      id_uses_rt   = $urandom_range(0, 1) == 1;
      ex_is_load   = $urandom_range(0, 1) == 1;
      ex_regwrite  = $urandom_range(0, 3) != 0;
      mem_br_taken = $urandom_range(0, 3) == 0;
      mem_req      = $urandom_range(0, 1) == 1;
      mem_ready    = $urandom_range(0, 3) != 0;
      @(negedge clk);
      check("rnd_vec", act_vec, model_vec());
      check("rnd_mem_err", mem_err, m_err);
      check("rnd_stall_cnt", stall_cnt, m_stall);
      check("rnd_flush_cnt", flush_cnt, m_flush);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
